// File: rtl/uart_rx_os.sv
// UART receiver: 8N1-style frames, LSB first, idle-high line, 16x oversampling.
// Samples each bit at its midpoint, rejects short start glitches, flags framing
// errors and overruns, and holds each good byte in a valid/ready register.
module uart_rx_os #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SW  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned IW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } state_e;

  state_e               state_q, state_d;
  logic                 rx_meta_q, rx_s_q, rx_prev_q;
  logic [CW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [SW-1:0]        sub_q, sub_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 tick, tick_clr, fall;

  assign tick = (tick_cnt_q == CW'(DIV - 1));
  assign fall = rx_prev_q & ~rx_s_q;

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // State, counters, shift register and output holding registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      tick_cnt_q <= '0;
      sub_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      sub_q      <= sub_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  // Next-state logic: frame sequencing, sampling and holding-register handshake.
  always_comb begin
    state_d  = state_q;
    sub_d    = sub_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    data_d   = data_q;
    valid_d  = valid_q;
    ferr_d   = 1'b0;
    ovr_d    = 1'b0;
    tick_clr = 1'b0;

    // Consumer pop; a same-cycle load below overrides this.
    if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (fall) begin
          state_d  = StStart;
          tick_clr = 1'b1;  // align the sampling phase to the detected edge
          sub_d    = '0;
        end
      end
      StStart: begin
        if (tick) begin
          if (sub_q == SW'(OVERSAMPLE / 2 - 1)) begin
            sub_d = '0;
            idx_d = '0;
            if (!rx_s_q) begin
              state_d = StData;
            end else begin
              state_d = StIdle;  // line went back high: glitch
            end
          end else begin
            sub_d = sub_q + 1'b1;
          end
        end
      end
      StData: begin
        if (tick) begin
          if (sub_q == SW'(OVERSAMPLE - 1)) begin
            sub_d          = '0;
            shift_d[idx_q] = rx_s_q;
            if (idx_q == IW'(DATA_BITS - 1)) begin
              state_d = StStop;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            sub_d = sub_q + 1'b1;
          end
        end
      end
      StStop: begin
        if (tick) begin
          if (sub_q == SW'(OVERSAMPLE - 1)) begin
            sub_d = '0;
            if (rx_s_q) begin
              if (!valid_q || rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
              end else begin
                ovr_d = 1'b1;
              end
              // Re-arm at mid stop bit to absorb transmitter clock skew.
              state_d = StIdle;
            end else begin
              ferr_d  = 1'b1;
              state_d = StBreak;
            end
          end else begin
            sub_d = sub_q + 1'b1;
          end
        end
      end
      StBreak: begin
        if (rx_s_q) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (tick_clr || tick) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + 1'b1;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os at default parameters (864 clk per bit).
module tb_uart_rx_os;

  localparam int BIT = 864;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  int total = 0;
  int bad = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         hold_low;
    logic       consume;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_ferr;
    int         exp_ovr;
  } vec_t;

  uart_rx_os dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Pulse counters for the one-cycle error outputs.
  always @(posedge clk) begin
    if (frame_err === 1'b1) ferr_cnt++;
    if (overrun === 1'b1) ovr_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one frame; the start edge is placed 1 time unit after a rising edge.
  task automatic send_frame(input logic [7:0] data, input logic stop);
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (BIT) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx = data[i];
      repeat (BIT) @(posedge clk);
    end
    #1 rx = stop;
    repeat (BIT) @(posedge clk);
    #1 rx = 1'b1;
  endtask

  task automatic consume();
    @(posedge clk);
    #1 rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
  endtask

  vec_t vecs[5];
  int   fb, ob, cnt;

  initial begin
    vecs[0] = '{8'h3C, 1'b0, 2000, 1'b0, 1'b0, 8'h3C, 1, 0};
    vecs[1] = '{8'h55, 1'b1, 0,    1'b1, 1'b1, 8'h55, 0, 0};
    vecs[2] = '{8'h11, 1'b1, 0,    1'b0, 1'b1, 8'h11, 0, 0};
    vecs[3] = '{8'h22, 1'b1, 0,    1'b1, 1'b1, 8'h11, 0, 1};
    vecs[4] = '{8'h11, 1'b1, 0,    1'b0, 1'b1, 8'h11, 0, 0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset rx_valid", rx_valid, 0);
    check("reset rx_data", rx_data, 0);
    check("reset busy", busy, 0);
    check("reset frame_err", frame_err, 0);
    check("reset overrun", overrun, 0);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);

    // First frame, latency to rx_valid measured from the start edge.
    fb = ferr_cnt;
    ob = ovr_cnt;
    cnt = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        @(posedge clk);
        while (rx_valid !== 1'b1 && cnt < 9000) begin
          @(posedge clk);
          #1 cnt++;
        end
        check("a5 latency in window", (cnt >= 8205 && cnt <= 8215), 1);
        check("a5 busy at valid", busy, 0);
      end
    join
    repeat (100) @(posedge clk);
    #1;
    check("a5 rx_valid", rx_valid, 1);
    check("a5 rx_data", rx_data, 8'hA5);
    check("a5 frame_err", ferr_cnt - fb, 0);
    check("a5 overrun", ovr_cnt - ob, 0);
    consume();
    #1 check("a5 consumed", rx_valid, 0);

    // Start glitch shorter than half a bit.
    fb = ferr_cnt;
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (10) @(posedge clk);
    #1 check("glitch busy high", busy, 1);
    repeat (290) @(posedge clk);
    #1 rx = 1'b1;
    repeat (450) @(posedge clk);
    #1;
    check("glitch busy low", busy, 0);
    check("glitch no valid", rx_valid, 0);
    check("glitch no frame_err", ferr_cnt - fb, 0);
    send_frame(8'h3C, 1'b1);
    repeat (100) @(posedge clk);
    #1;
    check("post-glitch rx_valid", rx_valid, 1);
    check("post-glitch rx_data", rx_data, 8'h3C);
    consume();
    #1 check("post-glitch consumed", rx_valid, 0);

    // Table-driven frames: framing error with break, good frames, overrun.
    for (int v = 0; v < 5; v++) begin
      fb = ferr_cnt;
      ob = ovr_cnt;
      send_frame(vecs[v].data, vecs[v].stop);
      if (vecs[v].hold_low > 0) begin
        rx = 1'b0;
        repeat (vecs[v].hold_low) @(posedge clk);
        #1 check($sformatf("v%0d busy in break", v), busy, 1);
        rx = 1'b1;
        repeat (20) @(posedge clk);
        #1 check($sformatf("v%0d busy after break", v), busy, 0);
      end
      repeat (100) @(posedge clk);
      #1;
      check($sformatf("v%0d rx_valid", v), rx_valid, vecs[v].exp_valid);
      check($sformatf("v%0d rx_data", v), rx_data, vecs[v].exp_data);
      check($sformatf("v%0d frame_err", v), ferr_cnt - fb, vecs[v].exp_ferr);
      check($sformatf("v%0d overrun", v), ovr_cnt - ob, vecs[v].exp_ovr);
      if (vecs[v].consume) begin
        consume();
        #1 check($sformatf("v%0d consumed", v), rx_valid, 0);
      end
    end

    // rx_ready asserted exactly in the cycle the next byte loads.
    ob = ovr_cnt;
    fork
      send_frame(8'h22, 1'b1);
      begin
        @(posedge clk);
        repeat (8210) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
      end
    join
    repeat (100) @(posedge clk);
    #1;
    check("pop+load overrun", ovr_cnt - ob, 0);
    check("pop+load rx_data", rx_data, 8'h22);
    check("pop+load rx_valid", rx_valid, 1);

    // Reset in the middle of data bit 3 of a 0xF0 frame.
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (BIT * 4 + BIT / 2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midreset rx_valid", rx_valid, 0);
    check("midreset rx_data", rx_data, 0);
    check("midreset busy", busy, 0);
    check("midreset frame_err", frame_err, 0);
    check("midreset overrun", overrun, 0);
    rx = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    fb = ferr_cnt;
    ob = ovr_cnt;
    repeat (1000) @(posedge clk);
    #1 check("post-reset idle valid", rx_valid, 0);
    send_frame(8'hF0, 1'b1);
    repeat (100) @(posedge clk);
    #1;
    check("f0 rx_valid", rx_valid, 1);
    check("f0 rx_data", rx_data, 8'hF0);
    check("f0 frame_err", ferr_cnt - fb, 0);
    check("f0 overrun", ovr_cnt - ob, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- UART receive engine with 16x oversampling, mid-bit sampling, start-glitch rejection, framing-error and overrun detection.
- Presents each received byte on a valid/ready holding register.
- Sits between the board RX pin (via the top-level UART block) and byte consumers: loopback path, display latch, command logic.
- Counterpart of the team's UART transmitter; same frame format: 8N1, LSB first, idle high.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 115200, line bit rate.
- OVERSAMPLE, 16, sample ticks per bit; even, >= 8.
- DATA_BITS, 8, data bits per frame, 5..8.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  raw asynchronous serial line, idle high.
- rx_data  output  DATA_BITS  last accepted byte; stable while rx_valid=1.
- rx_valid  output  1  rx_data holds an unconsumed byte.
- rx_ready  input  1  consumer accepts rx_data in any cycle with rx_valid=1.
- busy  output  1  high in any state other than IDLE.
- frame_err  output  1  one-cycle pulse; stop bit sampled low.
- overrun  output  1  one-cycle pulse; a good frame completed while the holding register was full.

Behaviour:
- Reset (rst_n=0, async):
  - Outputs: rx_data=0, rx_valid=0, busy=0, frame_err=0, overrun=0.
  - Synchronizer flops preset to 1; state=IDLE; all counters cleared.
- Reset mid-frame aborts the frame with no pulses. After release, the receiver needs a fresh high-to-low edge on the line.
- Input path: 2-flop synchronizer gives rx_s. A falling edge is rx_s=0 with the previous rx_s=1.
- Tick divider:
  - DIV = CLK_FREQ/(BAUD*OVERSAMPLE), truncated; 54 at defaults.
  - Tick counter counts 0..DIV-1 and emits a tick on DIV-1.
  - Counter is cleared on start detection so sampling phase aligns to the edge.
- State IDLE:
  - Waits for a falling edge on rx_s, then goes to START.
  - The tick counter and the sub-bit counter are cleared on entry to START.
- State START:
  - Waits OVERSAMPLE/2 ticks (mid start bit), then samples rx_s.
  - Sample 0 -> DATA with bit index 0 and sub-bit counter cleared.
  - Sample 1 -> IDLE as a glitch; no pulse.
- State DATA:
  - Every OVERSAMPLE ticks, samples rx_s into shift register bit [index], LSB first.
  - After DATA_BITS samples -> STOP.
- State STOP: after OVERSAMPLE ticks, samples rx_s.
  - Sample 1: frame good.
    - If rx_valid=0, or rx_ready=1 in the same cycle: rx_data <= shift register and rx_valid=1 on the next edge.
    - Else: overrun pulses 1 cycle, new byte is discarded, old rx_data and rx_valid are kept.
    - Next state IDLE. Re-arming at mid stop bit tolerates up to half a bit of transmitter clock skew.
  - Sample 0: frame_err pulses 1 cycle, rx_data/rx_valid unchanged, next state BREAK.
- State BREAK: waits until rx_s=1, then goes to IDLE. A held-low line produces exactly one frame_err.
- Handshake:
  - rx_valid clears on the edge after rx_valid=1 && rx_ready=1, unless a good frame loads in the same cycle; then it stays 1 with the new data.
  - rx_ready while rx_valid=0 is ignored.
- Latency: rx_valid rises 1 clk after the stop-sample tick; the sample itself sees rx delayed 2 clk by the synchronizer.
- Timing at defaults:
  - Bit period 864 clk; start sample 432 clk after the detected edge.
  - Total frame-to-valid time is about 9.5 bit periods.
- busy: combinational from state, 0 only in IDLE.

Test Plan:
- Defaults, send 0xA5 with stop=1, rx_ready=0 -> rx_valid=1, rx_data=0xA5 about 8208 clk after the start edge. busy drops at the stop sample; frame_err=0, overrun=0.
- Pulse rx low for 300 clk (< 432), then high -> busy high then low; no rx_valid, no frame_err; a following 0x3C frame is received correctly.
- Send 0x3C with the stop bit low, then hold rx low 2000 clk -> exactly one frame_err pulse; rx_valid stays 0; busy stays high until rx returns high; the next 0x55 frame is received.
- Send 0x11 then 0x22 back-to-back, rx_ready=0 -> rx_data=0x11, one overrun pulse at the end of the second frame. Then rx_ready=1 for one cycle -> rx_valid=0.
- Send 0x11, hold rx_ready=0, assert rx_ready exactly on the cycle 0x22 loads -> no overrun; rx_data=0x22; rx_valid stays 1.
- Assert rst_n=0 mid-frame during data bit 3 -> all outputs 0 immediately. Release; a following 0xF0 frame is received with no spurious pulses.
